// File: rtl/gb_joypad_if.sv
// CPU-side bus into the P1 joypad register: clock enable, address, write strobe/data, read data.
interface gb_joypad_if;
  logic        ce;
  logic [15:0] addr;
  logic        wr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (output ce, addr, wr, wdata, input rdata);
  modport slave  (input ce, addr, wr, wdata, output rdata);
endinterface

// File: rtl/gb_joypad.sv
// Game Boy P1 (0xFF00) joypad register: select-line matrix read-back, falling-edge
// joypad interrupt pulse and STOP-mode wake level.
module gb_joypad #(
  parameter logic [15:0] ADDR          = 16'hFF00,
  parameter bit          IRQ_ON_SELECT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  gb_joypad_if.slave       bus,
  input  logic [7:0]       buttons_i,
  output logic             irq_o,
  output logic             wake_o
);
  logic [1:0] sel_q, sel_d;
  logic [3:0] lines_q, lines_d;
  logic       irq_q, irq_d;

  logic       wr_hit;
  logic       sel_chg;
  logic [3:0] dir, act, fall;

  assign wr_hit  = bus.ce & bus.wr & (bus.addr == ADDR);
  assign sel_chg = wr_hit & (bus.wdata[5:4] != sel_q);

  // A write's new select is used in the same evaluation so select and lines never disagree.
  always_comb begin
    sel_d   = wr_hit ? bus.wdata[5:4] : sel_q;
    dir     = sel_d[0] ? 4'b0000 : buttons_i[3:0];
    act     = sel_d[1] ? 4'b0000 : buttons_i[7:4];
    lines_d = ~(dir | act);
    fall    = lines_q & ~lines_d;
    if (!IRQ_ON_SELECT && sel_chg)
      fall = 4'b0000;
    irq_d   = |fall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= 2'b11;
      lines_q <= 4'hF;
      irq_q   <= 1'b0;
    end else if (bus.ce) begin
      sel_q   <= sel_d;
      lines_q <= lines_d;
      irq_q   <= irq_d;
    end else begin
      irq_q   <= 1'b0;
    end
  end

  assign bus.rdata = (bus.addr == ADDR) ? {2'b11, sel_q, lines_q} : 8'hFF;
  assign irq_o     = irq_q;
  assign wake_o    = ~&lines_q;
endmodule

// File: tb/tb_gb_joypad.sv
// Directed bench for gb_joypad: two instances (select-caused irq enabled / disabled) on shared stimulus.
module tb_gb_joypad;
  logic        clk = 1'b0;
  logic        reset;
  logic        ce, wr;
  logic [15:0] addr;
  logic [7:0]  wdata, buttons;
  logic        irq1, wake1, irq0, wake0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  gb_joypad_if bif1 ();
  gb_joypad_if bif0 ();
  assign bif1.ce = ce;  assign bif1.addr = addr;  assign bif1.wr = wr;  assign bif1.wdata = wdata;
  assign bif0.ce = ce;  assign bif0.addr = addr;  assign bif0.wr = wr;  assign bif0.wdata = wdata;

  gb_joypad #(.ADDR(16'hFF00), .IRQ_ON_SELECT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bif1.slave), .buttons_i(buttons), .irq_o(irq1), .wake_o(wake1));
  gb_joypad #(.ADDR(16'hFF00), .IRQ_ON_SELECT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bif0.slave), .buttons_i(buttons), .irq_o(irq0), .wake_o(wake0));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] rd, input logic i1, input logic i0,
                         input logic wk);
    chk({tag, ".rd1"}, {8'h0, bif1.rdata}, {8'h0, rd});
    chk({tag, ".rd0"}, {8'h0, bif0.rdata}, {8'h0, rd});
    chk({tag, ".irq1"}, {15'h0, irq1}, {15'h0, i1});
    chk({tag, ".irq0"}, {15'h0, irq0}, {15'h0, i0});
    chk({tag, ".wake"}, {14'h0, wake1, wake0}, {14'h0, wk, wk});
  endtask

  task automatic cpu_wr(input logic [7:0] d);
    wr = 1'b1; wdata = d;
    step();
    wr = 1'b0; wdata = 8'h00;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; wr = 1'b0; addr = 16'hFF00; wdata = 8'h00; buttons = 8'hFF;
    step(); step();
    chk_all("rst", 8'hFF, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("idle", 8'hFF, 1'b0, 1'b0, 1'b0);
    end

    // directions group, press then release up
    buttons = 8'h00;
    cpu_wr(8'h20);
    chk_all("seldir", 8'hEF, 1'b0, 1'b0, 1'b0);
    buttons = 8'h04;
    step();
    chk_all("up", 8'hEB, 1'b1, 1'b1, 1'b1);
    step();
    chk_all("up_hold", 8'hEB, 1'b0, 1'b0, 1'b1);
    addr = 16'h0000; #1;
    chk("other_addr", {8'h0, bif1.rdata}, 16'h00FF);
    addr = 16'hFF00;
    buttons = 8'h00;
    step();
    chk_all("up_rel", 8'hEF, 1'b0, 1'b0, 1'b0);

    // actions group, A+start together -> single pulse
    cpu_wr(8'h10);
    chk_all("selact", 8'hDF, 1'b0, 1'b0, 1'b0);
    buttons = 8'h90;
    step();
    chk_all("a_start", 8'hD6, 1'b1, 1'b1, 1'b1);
    step();
    chk_all("a_start_h", 8'hD6, 1'b0, 1'b0, 1'b1);

    // select-caused fall: only the IRQ_ON_SELECT=1 instance pulses
    buttons = 8'h01;
    cpu_wr(8'h30);
    chk_all("desel", 8'hFF, 1'b0, 1'b0, 1'b0);
    cpu_wr(8'h20);
    chk_all("selfall", 8'hEE, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("selfall_h", 8'hEE, 1'b0, 1'b0, 1'b1);

    // both groups: wired-AND of B and right; sel change plus new fall
    buttons = 8'h21;
    cpu_wr(8'h00);
    chk_all("both", 8'hCC, 1'b1, 1'b0, 1'b1);
    ce = 1'b0;
    buttons = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("ce_low", 8'hCC, 1'b0, 1'b0, 1'b1);
    end
    ce = 1'b1;
    step();
    chk_all("ce_back", 8'hC0, 1'b1, 1'b1, 1'b1);

    // reset during the irq cycle, buttons still held
    reset = 1'b1;
    step();
    chk_all("rst_mid", 8'hFF, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_all("rst_1st", 8'hFF, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gb_joypad.md
# gb_joypad

Game Boy joypad register (P1, 0xFF00) and joypad interrupt source. Consumes the eight debounced, active-high button levels from the input debouncer and presents them to the CPU bus through the two select lines, as on DMG hardware. Detects high-to-low transitions on the P10–P13 input lines and raises a one-cycle joypad interrupt request toward the interrupt controller. Also drives a level wake signal for STOP-mode exit.

## Interface

- ADDR, 16'hFF00, bus address of the P1 register
- IRQ_ON_SELECT, 1, 1: falling lines caused by a select-bit write also request an interrupt; 0: only button-caused falls request one

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  CPU clock enable; all state except reset updates only when ce=1
- addr  in  16  CPU address
- wr  in  1  CPU write strobe, qualified by ce
- wdata  in  8  CPU write data
- rdata  out  8  P1 read value, valid whenever addr==ADDR, 8'hFF otherwise
- buttons  in  8  debounced levels, 1=pressed: [7]start [6]select [5]B [4]A [3]down [2]up [1]left [0]right
- irq  out  1  joypad interrupt request, one clk-cycle pulse
- wake  out  1  level: any P10–P13 line currently low

## Operation

- State: sel_q[1:0] (P15,P14; 0=group selected), lines_q[3:0] (registered P13–P10, 0=pressed), irq_q.
- Write: ce & wr & addr==ADDR -> sel_q <= wdata[5:4]; other wdata bits ignored.
- Line function, evaluated with effective select sel_n (= wdata[5:4] on a qualifying write cycle, else sel_q):
  - dir = sel_n[0]==0 ? buttons[3:0] : 4'b0
  - act = sel_n[1]==0 ? buttons[7:4] : 4'b0
  - lines_n = ~(dir | act)
- On every ce: lines_q <= lines_n.
- Falling detect on ce: fall = lines_q & ~lines_n (per bit). irq_q <= |fall. If IRQ_ON_SELECT=0 and the cycle is a qualifying write that changes sel, fall is masked to 0 for that cycle.
- On cycles with ce=0: irq_q <= 0; lines_q, sel_q hold.
- rdata = {2'b11, sel_q, lines_q} when addr==ADDR, else 8'hFF (combinational from registers).
- wake = ~&lines_q.
- Both groups selected: lines are the AND (wired-low) of both groups.
- Neither group selected: lines_n = 4'hF; no falls possible.

## Timing

- Reset values: sel_q=2'b11, lines_q=4'hF, irq=0, wake=0, rdata=8'hFF for addr==ADDR (both groups deselected).
- Reset has priority over ce and writes; a reset mid-pulse clears irq in the same edge.
- First ce after reset: no irq, since select is 11 and lines stay 4'hF regardless of held buttons.
- Latency, button -> rdata: buttons change before ce edge N -> lines_q and rdata reflect it after edge N.
- Latency, button -> irq: irq high for exactly the one clk cycle following ce edge N, then low (ce=0 next cycle forces 0; ce=1 next cycle re-evaluates with fall=0 unless a new fall occurs).
- Write -> rdata: sel_q and lines_q both update on the write edge; a read in the following cycle shows new select and new lines together, never a mixed state.
- Simultaneous write and button change on one ce: both applied in one lines_n evaluation; a single irq pulse covers any combination of falls.
- Rising lines (release or deselect) never generate irq.
- Multiple bits falling in one ce: one irq pulse, not one per bit.

## Test plan

- Reset with buttons=8'hFF, ce=1 continuously -> rdata=8'hFF, irq stays 0, wake=0 for 10 cycles.
- Write 8'h20 (select directions), buttons=8'h00, then buttons=8'h04 (up) -> after next ce rdata=8'hEB, irq one cycle high, wake=1; release -> rdata=8'hEF, no irq.
- Write 8'h10 (select actions), press A+start (buttons=8'h90) on one ce -> rdata=8'hD6, exactly one irq pulse.
- Buttons=8'h01 held, sel=11, then write 8'h20: IRQ_ON_SELECT=1 -> irq pulse and rdata=8'hEE; IRQ_ON_SELECT=0 -> no irq, rdata=8'hEE.
- Write 8'h00 with buttons=8'h21 (B+right) -> rdata=8'hCC; ce held low 5 cycles while buttons change -> rdata and irq unchanged until next ce.
- Assert reset during the irq cycle with buttons pressed -> irq=0, rdata=8'hFF after the reset edge; no irq on the first ce after reset.
